// File: rtl/m_wb_gpio_pwm.sv
// Wishbone classic GPIO slave: NCH output channels with set/clear/toggle access,
// per-channel shadowed PWM dimming and 2-FF synchronised input readback.
module m_wb_gpio_pwm #(
  parameter int             NCH      = 4,
  parameter int             PWMBITS  = 8,
  parameter logic [NCH-1:0] RESETVAL = '0
) (
  input  logic           CLK_I,
  input  logic           RST_N_I,
  input  logic           CYC_I,
  input  logic           STB_I,
  input  logic           WE_I,
  input  logic [2:0]     ADR_I,
  input  logic [31:0]    DAT_I,
  input  logic [3:0]     SEL_I,
  output logic [31:0]    DAT_O,
  output logic           ACK_O,
  input  logic [NCH-1:0] pin_i,
  output logic [NCH-1:0] pin_o
);

  logic                        ack_q, ack_d;
  logic [31:0]                 dat_q, dat_d;
  logic [NCH-1:0]              out_q, out_d;
  logic [NCH-1:0]              pwmen_q, pwmen_d;
  logic [NCH-1:0][PWMBITS-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][PWMBITS-1:0] active_q, active_d;
  logic [7:0]                  presc_q, presc_d;
  logic [7:0]                  pcnt_q, pcnt_d;
  logic [PWMBITS-1:0]          cnt_q, cnt_d;
  logic [NCH-1:0]              sync1_q, sync2_q;
  logic [NCH-1:0]              pin_q, pin_d;

  logic                        acc_s, wr_s, tick_s, wrap_s, duty_ok_s;
  logic [NCH-1:0]              mask_s, wdat_s, raw_s;
  logic [31:0]                 rdata_s;
  logic                        unused_s;

  // Data and select bits beyond those a given parameterisation consumes.
  assign unused_s = ^{DAT_I, SEL_I};

  // Handshake, register writes, prescaler/period counters and PWM output next-state.
  always_comb begin
    acc_s  = CYC_I & STB_I & ~ack_q;
    wr_s   = acc_s & WE_I;
    ack_d  = acc_s;
    mask_s = '0;
    for (int b = 0; b < NCH; b++) begin
      mask_s[b] = (b < 8) ? SEL_I[0] : SEL_I[1];
    end
    wdat_s    = DAT_I[NCH-1:0] & mask_s;
    duty_ok_s = wr_s & (ADR_I == 3'd6) & SEL_I[0] & SEL_I[2];
    tick_s    = (pcnt_q == presc_q);
    wrap_s    = tick_s & (cnt_q == '1);

    out_d   = out_q;
    pwmen_d = pwmen_q;
    presc_d = presc_q;
    pcnt_d  = tick_s ? 8'd0 : pcnt_q + 8'd1;
    cnt_d   = tick_s ? cnt_q + PWMBITS'(1) : cnt_q;

    if (wr_s) begin
      case (ADR_I)
        3'd0: out_d = (out_q & ~mask_s) | wdat_s;
        3'd1: out_d = out_q | wdat_s;
        3'd2: out_d = out_q & ~wdat_s;
        3'd3: out_d = out_q ^ wdat_s;
        3'd5: pwmen_d = (pwmen_q & ~mask_s) | wdat_s;
        3'd7: begin
          presc_d = SEL_I[0] ? DAT_I[7:0] : presc_q;
          pcnt_d  = SEL_I[0] ? 8'd0 : pcnt_d;
        end
        default: out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end

    // A DUTY write on the wrap edge lands in active directly via shadow_d.
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = (duty_ok_s && (DAT_I[19:16] == 4'(i))) ? DAT_I[PWMBITS-1:0] : shadow_q[i];
      active_d[i] = wrap_s ? shadow_d[i] : active_q[i];
      raw_s[i]    = (cnt_q < active_q[i]);
      pin_d[i]    = pwmen_q[i] ? (out_q[i] & raw_s[i]) : out_q[i];
    end
  end

  // Read-data multiplexer; sampled into DAT_O only on the edge a read is acked.
  always_comb begin
    case (ADR_I)
      3'd0:    rdata_s = 32'(out_q);
      3'd4:    rdata_s = 32'(sync2_q);
      3'd5:    rdata_s = 32'(pwmen_q);
      3'd7:    rdata_s = 32'(presc_q);
      default: rdata_s = 32'd0;
    endcase
    dat_d = (acc_s & ~WE_I) ? rdata_s : 32'd0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      out_q    <= RESETVAL;
      pwmen_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      presc_q  <= 8'd0;
      pcnt_q   <= 8'd0;
      cnt_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      pin_q    <= RESETVAL;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      out_q    <= out_d;
      pwmen_q  <= pwmen_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      pin_q    <= pin_d;
    end
  end

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign pin_o = pin_q;

endmodule
